// File: rtl/key_arb_pkg.sv
`default_nettype none
// ============================================================================
// key_arb_pkg
// ----------------------------------------------------------------------------
// Shared types and helpers for the key event arbiter.
//   arb_state_t : output slot state (IDLE / OFFER)
//   DROP_W      : width of the saturating drop counter
//   HOLD_W      : width of the per-key auto-repeat hold timer
//   rr_next     : round-robin successor of an index, wrapping at n
// Revision: 1.0 - initial release
// ============================================================================
package key_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   localparam int DROP_W = 8;
   localparam int HOLD_W = 24;

   // Index following idx in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage : key_arb_pkg
`default_nettype wire

// File: rtl/key_repeat_timer.sv
`default_nettype none
// ============================================================================
// key_repeat_timer
// ----------------------------------------------------------------------------
// Hold timer for one key. While 'pressed' is high the timer counts held
// cycles; the first repeat fires on the REPEAT_DELAY-th held cycle, later
// repeats every REPEAT_PERIOD held cycles. Releasing the key clears it.
// Only instantiated when KEY_ARB_REPEAT_EN is defined.
//
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-high reset
//   pressed      in  key level, high while held
//   repeat_pulse out one-cycle repeat event (combinational from pressed)
// Revision: 1.0 - initial release
// ============================================================================
module key_repeat_timer
   import key_arb_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 12_500_000,
   parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic pressed,
   output logic repeat_pulse
);

   logic [HOLD_W-1:0] hold_cnt;
   logic              in_period;   // first repeat already issued in this hold
   logic [HOLD_W-1:0] limit;

   // hold_cnt equals (held cycles - 1) in the current interval, so comparing
   // against interval-1 fires exactly on the interval-th held cycle.
   assign limit        = in_period ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);
   assign repeat_pulse = pressed && (hold_cnt == limit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt  <= '0;
         in_period <= 1'b0;
      end else if (!pressed) begin
         hold_cnt  <= '0;
         in_period <= 1'b0;
      end else if (repeat_pulse) begin
         hold_cnt  <= '0;
         in_period <= 1'b1;
      end else begin
         hold_cnt  <= hold_cnt + HOLD_W'(1);
      end
   end

endmodule : key_repeat_timer
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// ============================================================================
// key_event_arbiter
// ----------------------------------------------------------------------------
// Queues one-cycle key pulses per key in saturating pending counters and
// serialises them round-robin onto a single valid/ready event channel.
// Events arriving at a full counter are dropped and counted.
// Optional feature macro: KEY_ARB_REPEAT_EN (per-key auto-repeat timers).
//
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous active-high reset
//   key_pulse    in  [NUM_KEYS] one-cycle press pulse per key
//   key_pressed  in  [NUM_KEYS] key held level (auto-repeat only)
//   evt_ready    in  consumer accepts the offered event
//   evt_valid    out event offered (registered)
//   evt_id       out index of offered key (registered)
//   drop_cnt     out saturating count of dropped events
//   pending_any  out any pending counter non-zero (registered from counters)
// Revision: 1.0 - initial release
// ============================================================================
module key_event_arbiter
   import key_arb_pkg::*;
#(
   parameter int          NUM_KEYS      = 4,
   parameter int          PEND_W        = 2,
   parameter int unsigned REPEAT_DELAY  = 12_500_000,
   parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_KEYS-1:0]         key_pulse,
   input  logic [NUM_KEYS-1:0]         key_pressed,
   input  logic                        evt_ready,
   output logic                        evt_valid,
   output logic [$clog2(NUM_KEYS)-1:0] evt_id,
   output logic [DROP_W-1:0]           drop_cnt,
   output logic                        pending_any
);

   localparam int ID_W = $clog2(NUM_KEYS);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   arb_state_t          state;
   logic [PEND_W-1:0]   pend [NUM_KEYS];
   logic [ID_W-1:0]     rr_ptr;

   logic [NUM_KEYS-1:0] key_evt;     // pulse and repeat merged: one event per cycle
   logic [NUM_KEYS-1:0] nz;          // per-key pending counter non-zero
   logic [NUM_KEYS-1:0] load_vec;    // key k moves into the output slot this cycle
   logic [NUM_KEYS-1:0] drop_vec;    // key k event lost on a full counter
   logic                load;
   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W-1:0]     cand;

   // ------------------------------------------------------------------
   // Event sources
   // ------------------------------------------------------------------
`ifdef KEY_ARB_REPEAT_EN
   logic [NUM_KEYS-1:0] rep_pulse;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rep
      key_repeat_timer #(
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_timer (
         .clk          (clk),
         .reset        (reset),
         .pressed      (key_pressed[k]),
         .repeat_pulse (rep_pulse[k])
      );
   end

   assign key_evt = key_pulse | rep_pulse;
`else
   // Held level and repeat timing have no function without the timers.
   logic unused_cfg;
   assign unused_cfg = ^{key_pressed, REPEAT_DELAY, REPEAT_PERIOD};
   assign key_evt    = key_pulse;
`endif

   // ------------------------------------------------------------------
   // Round-robin grant from registered counters
   // ------------------------------------------------------------------
   assign evt_valid = (state == OFFER);
   assign load      = !evt_valid || evt_ready;

   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         nz[k] = (pend[k] != '0);
      end
   end

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = rr_ptr;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (!grant_found && nz[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
         cand = ID_W'(rr_next(32'(cand), NUM_KEYS));
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         load_vec[k] = load && grant_found && (grant_idx == ID_W'(k));
         drop_vec[k] = key_evt[k] && !load_vec[k] && (pend[k] == PEND_MAX);
      end
   end

   // ------------------------------------------------------------------
   // Pending counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            pend[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_evt[k] && !load_vec[k]) begin
               if (pend[k] != PEND_MAX) begin
                  pend[k] <= pend[k] + PEND_W'(1);
               end
            end else if (!key_evt[k] && load_vec[k]) begin
               pend[k] <= pend[k] - PEND_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output slot, round-robin pointer, status
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         evt_id <= '0;
         rr_ptr <= '0;
      end else if (load) begin
         if (grant_found) begin
            state  <= OFFER;
            evt_id <= grant_idx;
            rr_ptr <= ID_W'(rr_next(32'(grant_idx), NUM_KEYS));
         end else begin
            // Either already idle, or the last offer was just accepted.
            state  <= IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt    <= '0;
         pending_any <= 1'b0;
      end else begin
         pending_any <= |nz;
         if ((|drop_vec) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

endmodule : key_event_arbiter
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// ============================================================================
// tb_key_event_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for key_event_arbiter. Expected key ids are queued as
// stimulus is driven and compared on every accepted handshake; directed
// checks cover timing, saturation, drop counting and reset behaviour.
// The auto-repeat scenario is built only with KEY_ARB_REPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_event_arbiter;

   localparam int NK = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NK-1:0] key_pulse = '0;
   logic [NK-1:0] key_pressed = '0;
   logic          evt_ready = 1'b0;
   logic          evt_valid;
   logic [1:0]    evt_id;
   logic [7:0]    drop_cnt;
   logic          pending_any;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int hs0;
   int exp_q[$];

   key_event_arbiter #(
      .NUM_KEYS      (NK),
      .PEND_W        (2),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_pulse   (key_pulse),
      .key_pressed (key_pressed),
      .evt_ready   (evt_ready),
      .evt_valid   (evt_valid),
      .evt_id      (evt_id),
      .drop_cnt    (drop_cnt),
      .pending_any (pending_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted event must match the next queued id.
   always @(negedge clk) begin
      if (!reset && evt_valid && evt_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) check("unexpected_evt", int'(evt_id), -1);
         else                   check("evt_id", int'(evt_id), exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      key_pulse   = '0;
      key_pressed = '0;
      evt_ready   = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset values ----------------
      @(negedge clk);
      check("rst_valid", int'(evt_valid), 0);
      check("rst_id", int'(evt_id), 0);
      check("rst_drop", int'(drop_cnt), 0);
      check("rst_pend_any", int'(pending_any), 0);
      tick();
      reset = 1'b0;
      tick();

      // ---------------- single key, latency t+2 ----------------
      evt_ready = 1'b1;
      key_pulse = 4'b0100;
      exp_q.push_back(2);
      @(negedge clk); check("t1_valid_t0", int'(evt_valid), 0);
      tick(); key_pulse = '0;
      @(negedge clk); check("t1_valid_t1", int'(evt_valid), 0);
      tick();
      @(negedge clk);
      check("t1_valid_t2", int'(evt_valid), 1);
      check("t1_id_t2", int'(evt_id), 2);
      check("t1_pend_any_t2", int'(pending_any), 1);
      tick();
      @(negedge clk);
      check("t1_valid_t3", int'(evt_valid), 0);
      check("t1_pend_any_t3", int'(pending_any), 0);

      // ---------------- burst 1011 twice, back-to-back ----------------
      do_reset();
      evt_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         key_pulse = 4'b1011;
         exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
         tick(); key_pulse = '0;
         tick();
         for (int e = 0; e < 3; e++) begin
            @(negedge clk); check("t2_valid_run", int'(evt_valid), 1);
            tick();
         end
         @(negedge clk); check("t2_valid_end", int'(evt_valid), 0);
      end
      check("t2_sb_empty", exp_q.size(), 0);

      // ---------------- saturation with consumer stalled ----------------
      do_reset();
      evt_ready = 1'b0;
      key_pulse = 4'b0010;
      repeat (5) tick();
      key_pulse = '0;
      @(negedge clk);
      check("t3_valid", int'(evt_valid), 1);
      check("t3_id", int'(evt_id), 1);
      check("t3_drop", int'(drop_cnt), 1);
      check("t3_pend1", int'(dut.pend[1]), 3);
      check("t3_pend_any", int'(pending_any), 1);
      tick(); tick();
      @(negedge clk); check("t3_id_held", int'(evt_id), 1);
      repeat (4) exp_q.push_back(1);
      hs0 = hs_cnt;
      evt_ready = 1'b1;
      repeat (7) tick();
      @(negedge clk);
      check("t3_events", hs_cnt - hs0, 4);
      check("t3_valid_end", int'(evt_valid), 0);
      check("t3_drop_end", int'(drop_cnt), 1);

      // ---------------- event coinciding with load of same key ----------------
      do_reset();
      evt_ready = 1'b1;
      key_pulse = 4'b0001;
      exp_q.push_back(0);
      tick();                       // key 0 is loaded at the end of this cycle
      exp_q.push_back(0);
      tick(); key_pulse = '0;
      @(negedge clk);
      check("t4_valid_a", int'(evt_valid), 1);
      check("t4_id_a", int'(evt_id), 0);
      check("t4_pend0", int'(dut.pend[0]), 1);
      tick();
      @(negedge clk);
      check("t4_valid_b", int'(evt_valid), 1);
      check("t4_id_b", int'(evt_id), 0);
      tick();
      @(negedge clk); check("t4_valid_end", int'(evt_valid), 0);
      check("t4_sb_empty", exp_q.size(), 0);

      // ---------------- reset mid-offer ----------------
      do_reset();
      evt_ready = 1'b0;
      key_pulse = 4'b0011;
      tick(); key_pulse = '0;
      repeat (2) tick();
      @(negedge clk);
      check("t5_pre_valid", int'(evt_valid), 1);
      check("t5_pre_pend_any", int'(pending_any), 1);
      tick();
      reset = 1'b1;
      #1;
      check("t5_async_valid", int'(evt_valid), 0);
      check("t5_async_pend_any", int'(pending_any), 0);
      check("t5_async_pend0", int'(dut.pend[0]), 0);
      check("t5_async_pend1", int'(dut.pend[1]), 0);
      tick();
      reset = 1'b0;
      evt_ready = 1'b1;
      hs0 = hs_cnt;
      repeat (6) tick();
      @(negedge clk);
      check("t5_no_events", hs_cnt - hs0, 0);
      check("t5_valid_idle", int'(evt_valid), 0);

`ifdef KEY_ARB_REPEAT_EN
      // ---------------- auto-repeat: held 22 cycles ----------------
      do_reset();
      evt_ready = 1'b1;
      key_pressed = 4'b0100;
      repeat (4) exp_q.push_back(2);
      hs0 = hs_cnt;
      repeat (22) tick();
      key_pressed = '0;
      repeat (6) tick();
      @(negedge clk);
      check("t6_repeat_events", hs_cnt - hs0, 4);
      check("t6_drop", int'(drop_cnt), 0);
`endif

      check("final_sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_key_event_arbiter
`default_nettype wire

// File: doc/key_event_arbiter.md
# key_event_arbiter

Collects one-cycle key press pulses from up to `NUM_KEYS` keyboard key decoders and queues them per key. It serialises them round-robin onto a single valid/ready event channel consumed by the game/display control logic. It sits between the bank of key decoders and the one consumer that can accept only one key event per handshake. It also counts events lost to queue saturation.

## Interface
- `NUM_KEYS`, 4, number of key decoder inputs (2..16)
- `PEND_W`, 2, width of per-key pending counter; saturates at 2^PEND_W-1
- `REPEAT_DELAY`, 12_500_000, hold cycles before first auto-repeat (used only with `KEY_ARB_REPEAT_EN`)
- `REPEAT_PERIOD`, 2_500_000, cycles between later auto-repeats (used only with `KEY_ARB_REPEAT_EN`)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `key_pulse`  in  NUM_KEYS  one-cycle rising-edge pulse per key from its decoder
- `key_pressed`  in  NUM_KEYS  level, high while key held (repeat timing only)
- `evt_ready`  in  1  consumer accepts the offered event this cycle
- `evt_valid`  out  1  event offered
- `evt_id`  out  $clog2(NUM_KEYS)  index of the key for the offered event
- `drop_cnt`  out  8  saturating count of events lost on full pending counters
- `pending_any`  out  1  OR of all pending counters non-zero (registered state, not including the output slot)

## Operation
- Per-key pending counter `pend[k]` (PEND_W bits, reset 0).
  - Increment on a key event; decrement when key k is loaded into the output slot.
  - Event and load of k in the same cycle: net unchanged.
  - Event while `pend[k]` is at max and not loaded: counter unchanged, `drop_cnt` +1 (saturates at 255).
  - Several keys dropping in one cycle: `drop_cnt` +1 total per cycle.
- Output slot FSM, two states:
  - IDLE: `evt_valid`=0.
  - OFFER: `evt_valid`=1, `evt_id` held stable.
- Load condition: `!evt_valid || evt_ready`. On load:
  - If any `pend` is non-zero, grant the first non-zero key searching from `rr_ptr` upward with wrap. Go to or stay in OFFER, and set `rr_ptr` to granted+1 mod NUM_KEYS.
  - If none are pending and `evt_ready` was high, go to IDLE.
- OFFER with `evt_ready`=0: hold `evt_id`. No new grant is made and `rr_ptr` does not change.
- `rr_ptr` resets to 0.
- Reset mid-offer: `evt_valid` drops asynchronously and all pending events and counters are cleared.

## Timing
- Key pulse at cycle t: `pend` updated at the end of t. If the slot is free, `evt_valid`/`evt_id` become valid in cycle t+2.
- Back-to-back: with `evt_ready` held high and keys pending, one event per cycle, no bubble.
- `evt_valid` and `evt_id` are registered outputs. `evt_ready` reaches no output combinationally.
- `pending_any` is registered from `pend`, so it lags by one cycle relative to `pend`.
- Reset values: `evt_valid`=0, `evt_id`=0, `drop_cnt`=0, `pending_any`=0.

## Configuration
- `KEY_ARB_REPEAT_EN` defined: each key gets a hold timer (24 bits).
  - While `key_pressed[k]`=1 the timer counts. Reaching `REPEAT_DELAY` injects a repeat event, then the timer reloads for `REPEAT_PERIOD` and injects again at each expiry.
  - `key_pressed[k]`=0 clears the timer.
  - A repeat event and a `key_pulse` on the same key in the same cycle count as one event.
- Macro not defined: no timers are built, `key_pressed` is unused, and the repeat parameters are ignored.

## Structure
- Package `key_arb_pkg`:
  - state typedef `arb_state_t` {IDLE, OFFER}
  - `DROP_W`=8
  - `HOLD_W`=24
  - function computing the round-robin next index
- Sub-module `key_repeat_timer`, one instance per key, generated only under `KEY_ARB_REPEAT_EN`.
  - Inputs: `clk`, `reset`, `pressed`.
  - Output: `repeat_pulse`.

## Test plan
- Reset released, `key_pulse`=4'b0100 for one cycle, `evt_ready`=1. Expected: `evt_valid` high in cycle t+2 for exactly 1 cycle with `evt_id`=2; `pending_any` returns to 0.
- `key_pulse`=4'b1011 in one cycle, `evt_ready`=1. Expected: events on consecutive cycles with ids 0, 1, 3; a second burst of 4'b1011 then yields 0, 1, 3 again.
- `evt_ready`=0 and key 1 pulsed 5 times (PEND_W=2). Expected: `evt_id`=1 held in the slot, `pend[1]`=3, `drop_cnt`=1; after `evt_ready`=1, exactly 4 id-1 events.
- Key 0 pulsed at the same cycle key 0 is loaded into the slot with `pend[0]`=1. Expected: `pend[0]` stays 1 and a further id-0 event follows.
- `reset` asserted while `evt_valid`=1 and `pend` is non-zero. Expected: `evt_valid`=0 immediately, all counters 0, and no events after release.
- With `KEY_ARB_REPEAT_EN`, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=4, key 2 held for 22 cycles, `evt_ready`=1. Expected: repeat events for key 2 injected at hold counts 10, 14, 18 and 22 (4 events).
